alu_pwr_ctrl: RTL and testbench

- Always-on power sequencer that drives the ALU power-domain controls: alu_pwr_en, iso_en, save and restore.
- Converts level sleep/wake requests into ordered, timed power-down and power-up sequences.
- Sits in PD_AON next to aon_block; its outputs connect directly to the ALU power-control inputs, and it reads the ALU busy output.

---
 rtl/alu_pwr_ctrl_pkg.sv | 26 ++
 rtl/alu_pwr_ctrl_pwr_dly_cnt.sv | 37 +++
 rtl/alu_pwr_ctrl.sv | 144 ++++++++++++++
 tb/tb_alu_pwr_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu_pwr_ctrl_pkg.sv
// Shared constants for the ALU power sequencer: state encoding, state width
// and the default sequencing delays.
package alu_pwr_ctrl_pkg;

  localparam int ST_W           = 3;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_ISO_DLY    = 2;
  localparam int DEF_PWR_DN_DLY = 2;
  localparam int DEF_PWR_UP_DLY = 4;

  typedef enum logic [ST_W-1:0] {
    ST_ON      = 3'd0,
    ST_ISO     = 3'd1,
    ST_SAVE    = 3'd2,
    ST_PWR_DN  = 3'd3,
    ST_OFF     = 3'd4,
    ST_PWR_UP  = 3'd5,
    ST_RESTORE = 3'd6
  } pwr_state_e;

  // A programmed delay of 0 still occupies the state for one cycle.
  function automatic int eff_dly(input int d);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/alu_pwr_ctrl_pwr_dly_cnt.sv
// Delay counter for the power sequencer: cleared on state entry, counts while
// enabled and holds once the programmed delay has elapsed.
module pwr_dly_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] dly,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last;

  assign last = (dly == '0) ? '0 : dly - CNT_W'(1);
  assign done = (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && !done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_pwr_ctrl.sv
// Always-on ALU power sequencer; all outputs are registered decodes of state.
// Optional macro ALU_PWR_CTRL_ACK_EN adds the pwr_ack power-switch handshake.
module alu_pwr_ctrl
  import alu_pwr_ctrl_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int ISO_DLY    = DEF_ISO_DLY,
  parameter int PWR_DN_DLY = DEF_PWR_DN_DLY,
  parameter int PWR_UP_DLY = DEF_PWR_UP_DLY
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sleep_req,
  input  logic            wake_req,
  input  logic            alu_busy,
`ifdef ALU_PWR_CTRL_ACK_EN
  input  logic            pwr_ack,
`endif
  output logic            alu_pwr_en,
  output logic            iso_en,
  output logic            save,
  output logic            restore,
  output logic            pd_on,
  output logic            pd_off,
  output logic [ST_W-1:0] pwr_state
);

  localparam int MAX_DLY = (2 ** CNT_W) - 1;
  localparam logic [CNT_W-1:0] ISO_D = CNT_W'(eff_dly(ISO_DLY));
  localparam logic [CNT_W-1:0] DN_D  = CNT_W'(eff_dly(PWR_DN_DLY));
  localparam logic [CNT_W-1:0] UP_D  = CNT_W'(eff_dly(PWR_UP_DLY));

  if (eff_dly(ISO_DLY) > MAX_DLY || eff_dly(PWR_DN_DLY) > MAX_DLY ||
      eff_dly(PWR_UP_DLY) > MAX_DLY) begin : g_dly_range_chk
    $fatal(1, "alu_pwr_ctrl: delay parameter exceeds 2**CNT_W-1");
  end

  pwr_state_e       state_q, state_d;
  logic [CNT_W-1:0] dly_sel;
  logic             cnt_en, cnt_load, cnt_done;
  logic             ack_up, ack_dn;

`ifdef ALU_PWR_CTRL_ACK_EN
  assign ack_up = pwr_ack;
  assign ack_dn = !pwr_ack;
`else
  assign ack_up = 1'b1;
  assign ack_dn = 1'b1;
`endif

  assign cnt_load = (state_d != state_q);

  pwr_dly_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .dly  (dly_sel),
    .done (cnt_done)
  );

  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    dly_sel = CNT_W'(1);
    unique case (state_q)
      ST_ON:      if (sleep_req && !alu_busy) state_d = ST_ISO;
      ST_ISO: begin
        cnt_en  = 1'b1;
        dly_sel = ISO_D;
        if (cnt_done) state_d = ST_SAVE;
      end
      ST_SAVE:    state_d = ST_PWR_DN;
      ST_PWR_DN: begin
        cnt_en  = 1'b1;
        dly_sel = DN_D;
        if (cnt_done && ack_dn) state_d = ST_OFF;
      end
      ST_OFF:     if (wake_req) state_d = ST_PWR_UP;
      ST_PWR_UP: begin
        cnt_en  = 1'b1;
        dly_sel = UP_D;
        if (cnt_done && ack_up) state_d = ST_RESTORE;
      end
      ST_RESTORE: state_d = ST_ON;
      default:    state_d = ST_ON;
    endcase
  end

  logic pwr_en_d, iso_d, save_d, restore_d, pd_on_d, pd_off_d;
  logic pwr_en_q, iso_q, save_q, restore_q, pd_on_q, pd_off_q;

  // Output decode of the current state, registered on the next edge.
  always_comb begin
    pwr_en_d  = 1'b1;
    iso_d     = 1'b1;
    save_d    = 1'b0;
    restore_d = 1'b0;
    pd_on_d   = 1'b0;
    pd_off_d  = 1'b0;
    unique case (state_q)
      ST_ON: begin
        iso_d   = 1'b0;
        pd_on_d = 1'b1;
      end
      ST_SAVE:    save_d = 1'b1;
      ST_OFF: begin
        pwr_en_d = 1'b0;
        pd_off_d = 1'b1;
      end
      ST_RESTORE: restore_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ON;
      pwr_en_q  <= 1'b1;
      iso_q     <= 1'b0;
      save_q    <= 1'b0;
      restore_q <= 1'b0;
      pd_on_q   <= 1'b1;
      pd_off_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwr_en_q  <= pwr_en_d;
      iso_q     <= iso_d;
      save_q    <= save_d;
      restore_q <= restore_d;
      pd_on_q   <= pd_on_d;
      pd_off_q  <= pd_off_d;
    end
  end

  assign alu_pwr_en = pwr_en_q;
  assign iso_en     = iso_q;
  assign save       = save_q;
  assign restore    = restore_q;
  assign pd_on      = pd_on_q;
  assign pd_off     = pd_off_q;
  assign pwr_state  = state_q;

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// Directed bench for alu_pwr_ctrl: reset, power-down/up timing, busy hold,
// non-abortable sequencing and reset in the middle of a power-down.
module tb_alu_pwr_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sleep_req = 1'b0;
  logic       wake_req = 1'b0;
  logic       alu_busy = 1'b0;
  logic       alu_pwr_en, iso_en, save, restore, pd_on, pd_off;
  logic [2:0] pwr_state;
  int         checks = 0;
  int         errors = 0;

`ifdef ALU_PWR_CTRL_ACK_EN
  logic pwr_ack;
  assign pwr_ack = alu_pwr_en;
`endif

  alu_pwr_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .sleep_req  (sleep_req),
    .wake_req   (wake_req),
    .alu_busy   (alu_busy),
`ifdef ALU_PWR_CTRL_ACK_EN
    .pwr_ack    (pwr_ack),
`endif
    .alu_pwr_en (alu_pwr_en),
    .iso_en     (iso_en),
    .save       (save),
    .restore    (restore),
    .pd_on      (pd_on),
    .pd_off     (pd_off),
    .pwr_state  (pwr_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sample 1ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_on_outputs(input string tag);
    chk({tag, ".pwr_en"},  {2'b0, alu_pwr_en}, 3'd1);
    chk({tag, ".iso"},     {2'b0, iso_en},     3'd0);
    chk({tag, ".save"},    {2'b0, save},       3'd0);
    chk({tag, ".restore"}, {2'b0, restore},    3'd0);
    chk({tag, ".pd_on"},   {2'b0, pd_on},      3'd1);
    chk({tag, ".pd_off"},  {2'b0, pd_off},     3'd0);
    chk({tag, ".state"},   pwr_state,          3'd0);
  endtask

  initial begin
    // Asynchronous reset, applied between clock edges with busy inputs.
    sleep_req = 1'b1;
    wake_req  = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_on_outputs("reset_async");
    step();
    step();
    chk_on_outputs("reset_held");
    rst       = 1'b0;
    sleep_req = 1'b0;
    wake_req  = 1'b0;
    step();
    chk_on_outputs("idle_on");

    // Power-down: sleep sampled at edge N, observed after edge N+i.
    sleep_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("pdn.iso[%0d]", i),    {2'b0, iso_en},     (i >= 1) ? 3'd1 : 3'd0);
      chk($sformatf("pdn.save[%0d]", i),   {2'b0, save},       (i == 3) ? 3'd1 : 3'd0);
      chk($sformatf("pdn.pwr_en[%0d]", i), {2'b0, alu_pwr_en}, (i >= 6) ? 3'd0 : 3'd1);
      chk($sformatf("pdn.pd_off[%0d]", i), {2'b0, pd_off},     (i >= 6) ? 3'd1 : 3'd0);
      chk($sformatf("pdn.pd_on[%0d]", i),  {2'b0, pd_on},      (i == 0) ? 3'd1 : 3'd0);
      chk($sformatf("pdn.restore[%0d]", i), {2'b0, restore},   3'd0);
      chk($sformatf("pdn.iso_cover[%0d]", i), {2'b0, iso_en | alu_pwr_en}, 3'd1);
      if (i == 2) chk("pdn.state_save", pwr_state, 3'd2);
      if (i == 4) chk("pdn.state_pwr_dn", pwr_state, 3'd3);
      if (i == 7) chk("pdn.state_off", pwr_state, 3'd4);
    end
    sleep_req = 1'b0;
    step();
    chk("off_hold.pwr_en", {2'b0, alu_pwr_en}, 3'd0);

    // Power-up: wake sampled at edge M.
    wake_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("pup.pwr_en[%0d]", i),  {2'b0, alu_pwr_en}, (i >= 1) ? 3'd1 : 3'd0);
      chk($sformatf("pup.restore[%0d]", i), {2'b0, restore},    (i == 5) ? 3'd1 : 3'd0);
      chk($sformatf("pup.iso[%0d]", i),     {2'b0, iso_en},     (i >= 6) ? 3'd0 : 3'd1);
      chk($sformatf("pup.pd_on[%0d]", i),   {2'b0, pd_on},      (i >= 6) ? 3'd1 : 3'd0);
      chk($sformatf("pup.pd_off[%0d]", i),  {2'b0, pd_off},     (i == 0) ? 3'd1 : 3'd0);
      chk($sformatf("pup.save[%0d]", i),    {2'b0, save},       3'd0);
    end
    wake_req = 1'b0;

    // Busy hold: sleep pending while the ALU is busy.
    alu_busy  = 1'b1;
    sleep_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("busy.iso[%0d]", i),   {2'b0, iso_en}, 3'd0);
      chk($sformatf("busy.pd_on[%0d]", i), {2'b0, pd_on},  3'd1);
    end
    alu_busy = 1'b0;
    step();
    chk("busy_drop.iso_K", {2'b0, iso_en}, 3'd0);
    step();
    chk("busy_drop.iso_K1", {2'b0, iso_en}, 3'd1);
    sleep_req = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("busy_seq.pd_off", {2'b0, pd_off}, 3'd1);
    wake_req = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("busy_seq.pd_on", {2'b0, pd_on}, 3'd1);
    wake_req = 1'b0;
    step();

    // Non-abort: one-cycle sleep pulse, wake held from ISO onward.
    sleep_req = 1'b1;
    step();
    sleep_req = 1'b0;
    wake_req  = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk($sformatf("nab.pwr_en[%0d]", i),  {2'b0, alu_pwr_en}, (i == 6) ? 3'd0 : 3'd1);
      chk($sformatf("nab.pd_off[%0d]", i),  {2'b0, pd_off},     (i == 6) ? 3'd1 : 3'd0);
      chk($sformatf("nab.pd_on[%0d]", i),   {2'b0, pd_on},      (i >= 12) ? 3'd1 : 3'd0);
      chk($sformatf("nab.save[%0d]", i),    {2'b0, save},       (i == 3) ? 3'd1 : 3'd0);
      chk($sformatf("nab.restore[%0d]", i), {2'b0, restore},    (i == 11) ? 3'd1 : 3'd0);
      chk($sformatf("nab.exclusive[%0d]", i), {2'b0, save & restore}, 3'd0);
    end
    wake_req = 1'b0;
    step();

    // Reset while in PWR_DN.
    sleep_req = 1'b1;
    step();
    sleep_req = 1'b0;
    for (int i = 1; i <= 4; i++) step();
    chk("mid.state_pwr_dn", pwr_state, 3'd3);
    chk("mid.iso_before", {2'b0, iso_en}, 3'd1);
    #3 rst = 1'b1;
    #1;
    chk_on_outputs("mid_reset");
    step();
    chk_on_outputs("mid_reset_held");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_on_outputs($sformatf("post_reset[%0d]", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
